multiplexador_nx1_arbitrado: RTL



---
 rtl/multiplexador_nx1_arbitrado.sv | 79 +++++++
 1 files changed

// File: rtl/multiplexador_nx1_arbitrado.sv
// Registered N-to-1 multiplexer with per-channel valid/ready handshake.
// Selects by M (MODO=0) or by round-robin among requesting channels (MODO=1).
module multiplexador_nx1_arbitrado #(
  parameter int unsigned LARGURA = 16,
  parameter int unsigned CANAIS  = 4,
  parameter int unsigned MODO    = 0,
  localparam int unsigned SEL_W  = ($clog2(CANAIS) > 1) ? $clog2(CANAIS) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CANAIS*LARGURA-1:0]   entrada,
  input  logic [CANAIS-1:0]           entrada_valida,
  output logic [CANAIS-1:0]           entrada_pronta,
  input  logic [SEL_W-1:0]            M,
  output logic [LARGURA-1:0]          resultado,
  output logic                        resultado_valido,
  input  logic                        resultado_pronto,
  output logic [SEL_W-1:0]            canal_atual
);

  logic [LARGURA-1:0] dado [CANAIS];
  logic [SEL_W-1:0]   ultimo;
  logic [SEL_W-1:0]   g;
  logic [SEL_W-1:0]   cand;
  logic               tem_grant;
  logic               carga;
  logic               transfere;

  for (genvar i = 0; i < CANAIS; i++) begin : g_desempacota
    assign dado[i] = entrada[i*LARGURA +: LARGURA];
  end

  // Grant: explicit index, or first requester after the last granted channel
  always_comb begin
    g         = '0;
    cand      = '0;
    tem_grant = 1'b0;
    if (MODO == 0) begin
      if (32'(M) < CANAIS) begin
        g         = M;
        tem_grant = 1'b1;
      end
    end else begin
      for (int unsigned k = 1; k <= CANAIS; k++) begin
        cand = SEL_W'((32'(ultimo) + k) % CANAIS);
        if (!tem_grant && entrada_valida[cand]) begin
          g         = cand;
          tem_grant = 1'b1;
        end
      end
    end
  end

  // Reset blocks acceptance so no producer believes its item was taken
  assign carga     = !resultado_valido | resultado_pronto;
  assign transfere = !reset & carga & tem_grant & entrada_valida[g];

  always_comb begin
    entrada_pronta = '0;
    if (transfere) entrada_pronta[g] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resultado        <= '0;
      resultado_valido <= 1'b0;
      canal_atual      <= '0;
      ultimo           <= SEL_W'(CANAIS - 1);
    end else if (transfere) begin
      resultado        <= dado[g];
      resultado_valido <= 1'b1;
      canal_atual      <= g;
      if (MODO == 1) ultimo <= g;
    end else if (resultado_pronto) begin
      resultado_valido <= 1'b0;
    end
  end

endmodule
